fec_cc_tailbite_enc: RTL and testbench

- Tail-biting convolutional encoder: rate 1/2, constraint length 7, generators G1=171 octal (X) and G2=133 octal (Y), per the 802.16 OFDM PHY.
- Sits directly downstream of the PRBS Randomizer. Consumes the randomizer's serial output one bit per clock, in blocks.
- Emits an X/Y bit pair per clock to the interleaver.
- Ping-pong block buffering lets block N+1 be accepted while block N is encoded.

---
 rtl/fec_cc_tailbite_enc.sv | 151 +++++++++++++++
 tb/tb_fec_cc_tailbite_enc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fec_cc_tailbite_enc.sv
// Tail-biting convolutional encoder, rate 1/2, K=7, G1=171 (X), G2=133 (Y).
// Two input banks ping-pong so one block can be written while the other is encoded.
// Each block is preloaded with its own last six bits so the encoder ends in the
// state it started in.
module fec_cc_tailbite_enc #(
   parameter int unsigned BLOCK_BITS = 96,
   parameter int unsigned CNT_W      = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_bit,
   output logic in_ready,
   output logic out_valid,
   output logic out_x,
   output logic out_y,
   output logic out_first,
   output logic out_last
);

   typedef enum logic [1:0] {StIdle, StPreload, StEncode} state_e;

   state_e                state_q, state_d;
   logic [BLOCK_BITS-1:0] bank_q [2];
   logic [1:0]            full_q, full_d;
   logic                  wr_bank_q, rd_bank_q;
   logic [CNT_W-1:0]      wr_cnt_q, rd_cnt_q;
   // sr_q[0] is s1 (most recent bit), sr_q[5] is s6 (oldest)
   logic [5:0]            sr_q;
   logic [5:0]            tail;
   logic                  in_fire, wr_last, rd_last, rd_bit, x_bit, y_bit;
   logic                  preload_en, enc_en, blk_done;
   logic                  out_valid_q, out_x_q, out_y_q, out_first_q, out_last_q;

   assign in_ready  = ~full_q[wr_bank_q];
   assign in_fire   = in_valid & in_ready;
   assign wr_last   = (wr_cnt_q == CNT_W'(BLOCK_BITS - 1));
   assign rd_last   = (rd_cnt_q == CNT_W'(BLOCK_BITS - 1));

   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;

   // Select the data bit being encoded and the tail-biting preload value
   always_comb begin
      rd_bit = 1'b0;
      for (int i = 0; i < BLOCK_BITS; i++) begin
         if (rd_cnt_q == CNT_W'(i)) rd_bit = bank_q[rd_bank_q][i];
      end
      tail = '0;
      for (int j = 0; j < 6; j++) begin
         tail[j] = bank_q[rd_bank_q][BLOCK_BITS-1-j];
      end
   end

   assign x_bit = rd_bit ^ sr_q[0] ^ sr_q[1] ^ sr_q[2] ^ sr_q[5];
   assign y_bit = rd_bit ^ sr_q[1] ^ sr_q[2] ^ sr_q[4] ^ sr_q[5];

   // Bank storage; contents are don't-care until the bank is marked full
   always_ff @(posedge clk) begin
      for (int i = 0; i < BLOCK_BITS; i++) begin
         if (in_fire && wr_cnt_q == CNT_W'(i)) bank_q[wr_bank_q][i] <= in_bit;
      end
   end

   // Bank occupancy: a finished read frees its bank before a completed write sets one
   always_comb begin
      full_d = full_q;
      if (blk_done) full_d[rd_bank_q] = 1'b0;
      if (in_fire && wr_last) full_d[wr_bank_q] = 1'b1;
   end

   // Write-side counters and bank occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
      end else begin
         full_q <= full_d;
         if (in_fire) begin
            if (wr_last) begin
               wr_cnt_q  <= '0;
               wr_bank_q <= ~wr_bank_q;
            end else begin
               wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next state; a full second bank skips IDLE so blocks are one cycle apart
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (full_q[rd_bank_q]) state_d = StPreload;
         StPreload: state_d = StEncode;
         StEncode:  if (rd_last) state_d = full_q[~rd_bank_q] ? StPreload : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // FSM output decode
   always_comb begin
      preload_en = (state_q == StPreload);
      enc_en     = (state_q == StEncode);
      blk_done   = enc_en & rd_last;
   end

   // Shift register, read counter and registered coded outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q        <= '0;
         rd_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= 1'b0;
         out_y_q     <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= enc_en;
         out_x_q     <= enc_en & x_bit;
         out_y_q     <= enc_en & y_bit;
         out_first_q <= enc_en & (rd_cnt_q == '0);
         out_last_q  <= blk_done;
         if (preload_en) begin
            sr_q     <= tail;
            rd_cnt_q <= '0;
         end
         if (enc_en) begin
            sr_q <= {sr_q[4:0], rd_bit};
            if (rd_last) begin
               rd_cnt_q  <= '0;
               rd_bank_q <= ~rd_bank_q;
            end else begin
               rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fec_cc_tailbite_enc.sv
// Bench for fec_cc_tailbite_enc: table of single blocks (802.16 vector, zeros,
// gapped, random) plus back-to-back/backpressure and mid-block reset sequences.
module tb_fec_cc_tailbite_enc;

   localparam int N = 96;
   localparam int W = 2 * N;
   localparam int NV = 6;
   localparam logic [N-1:0] VEC       = 96'h558AC4A53A1724E163AC2BF9;
   localparam logic [W-1:0] VEC_CODED = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic in_ready, out_valid, out_x, out_y, out_first, out_last;

   typedef struct {
      string        name;
      logic [N-1:0] data;
      bit           gapped;
      logic [W-1:0] exp;
   } vec_t;

   typedef struct {
      bit     x;
      bit     y;
      bit     first;
      bit     last;
      longint t;
   } pair_t;

   vec_t  vecs[NV];
   pair_t pq[$];
   int    tests = 0;
   int    fails = 0;

   fec_cc_tailbite_enc #(.BLOCK_BITS(N), .CNT_W(10)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_first(out_first),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Capture every valid pair with the time of the edge that produced it
   always @(negedge clk) begin
      if (out_valid) begin
         pair_t p;
         p.x = out_x; p.y = out_y; p.first = out_first; p.last = out_last;
         p.t = $time - 5;
         pq.push_back(p);
      end
   end

   // Data bit k of a block (k=0 is the first bit sent, i.e. the MSB)
   function automatic logic data_bit(input logic [N-1:0] blk, input int k);
      return blk[N-1-k];
   endfunction

   // Reference encoder straight from the generator polynomials, circular indexing
   function automatic logic [W-1:0] model_encode(input logic [N-1:0] blk);
      logic [W-1:0] r;
      logic         s [7];
      r = '0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j <= 6; j++) s[j] = data_bit(blk, (k - j + N) % N);
         r[W-1-2*k] = s[0] ^ s[1] ^ s[2] ^ s[3] ^ s[6];
         r[W-2-2*k] = s[0] ^ s[2] ^ s[3] ^ s[5] ^ s[6];
      end
      return r;
   endfunction

   // Encoder state at block end: s1 = last data bit ... s6 = sixth from last
   function automatic logic [5:0] tail_of(input logic [N-1:0] blk);
      logic [5:0] t;
      for (int j = 0; j < 6; j++) t[j] = data_bit(blk, N - 1 - j);
      return t;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive nbits of blk MSB-first; call at a negedge. Returns stalls and last transfer edge time.
   task automatic send_bits(input logic [N-1:0] blk, input int nbits, input bit gapped,
                            output int stalls, output longint t_last);
      stalls = 0;
      t_last = 0;
      for (int i = 0; i < nbits; i++) begin
         int guard;
         guard = 0;
         in_valid = 1'b1;
         in_bit   = blk[N-1-i];
         while (!in_ready && guard < 1000) begin
            @(negedge clk);
            stalls++;
            guard++;
         end
         if (guard >= 1000) begin
            check("send_timeout", W'(0), W'(1));
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         t_last = $time;
         @(negedge clk);
         if (gapped) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_pairs(input int n, input int budget);
      int g;
      g = 0;
      while (pq.size() < n && g < budget) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (pq.size() < n) check("pair_timeout", W'(pq.size()), W'(n));
   endtask

   // Stream, first/last flags, latency and contiguity of the block at pq[base]
   task automatic check_block(input string name, input int base, input logic [W-1:0] exp,
                              input longint t_last, input bit use_lat);
      logic [W-1:0] s;
      int nf, nl;
      s = '0; nf = 0; nl = 0;
      if (pq.size() < base + N) begin
         check({name, "_size"}, W'(pq.size()), W'(base + N));
         return;
      end
      for (int k = 0; k < N; k++) begin
         s[W-1-2*k] = pq[base+k].x;
         s[W-2-2*k] = pq[base+k].y;
         nf += int'(pq[base+k].first);
         nl += int'(pq[base+k].last);
      end
      check({name, "_stream"}, s, exp);
      check({name, "_first"}, W'({nf[7:0], pq[base].first}), W'({8'd1, 1'b1}));
      check({name, "_last"}, W'({nl[7:0], pq[base+N-1].last}), W'({8'd1, 1'b1}));
      check({name, "_contig"}, W'(pq[base+N-1].t - pq[base].t), W'((N - 1) * 10));
      if (use_lat) check({name, "_latency"}, W'(pq[base].t - t_last), W'(30));
   endtask

   initial begin
      int     st, s1, s2, s3;
      longint tl, t1, t2, t3;
      logic   pre;

      vecs[0] = '{"vector", VEC, 1'b0, VEC_CODED};
      vecs[1] = '{"zeros", '0, 1'b0, '0};
      vecs[2] = '{"gapped", VEC, 1'b1, VEC_CODED};
      for (int i = 3; i < NV; i++) begin
         logic [N-1:0] d;
         d = {$urandom, $urandom, $urandom};
         vecs[i] = '{$sformatf("rand%0d", i), d, bit'($urandom_range(0, 1)), model_encode(d)};
      end

      repeat (2) @(negedge clk);
      #1;
      check("reset_state", W'({out_valid, out_x, out_y, out_first, out_last, in_ready}),
            W'(6'b000001));
      @(negedge clk);
      reset = 1'b0;

      // Table of isolated blocks
      for (int i = 0; i < NV; i++) begin
         pq.delete();
         send_bits(vecs[i].data, N, vecs[i].gapped, st, tl);
         wait_pairs(N, 600);
         repeat (10) @(negedge clk);
         #1;
         check({vecs[i].name, "_count"}, W'(pq.size()), W'(N));
         check_block(vecs[i].name, 0, vecs[i].exp, tl, 1'b1);
         check({vecs[i].name, "_tail"}, W'(dut.sr_q), W'(tail_of(vecs[i].data)));
      end

      // Back-to-back three blocks; the third runs into both banks being full
      pq.delete();
      send_bits(VEC, N, 1'b0, s1, t1);
      send_bits('0, N, 1'b0, s2, t2);
      send_bits(VEC, N, 1'b0, s3, t3);
      wait_pairs(3 * N, 800);
      repeat (10) @(negedge clk);
      #1;
      check("b2b_count", W'(pq.size()), W'(3 * N));
      check("b2b_ready_blk1", W'(s1), W'(0));
      check("b2b_ready_blk2", W'(s2), W'(0));
      check("bp_stall_cycles", W'(s3), W'(2));
      check("bp_bit_timing", W'(t3 - t1), W'((2 * N + 2) * 10));
      check_block("b2b_blk1", 0, VEC_CODED, t1, 1'b1);
      check_block("b2b_blk2", N, '0, 0, 1'b0);
      check_block("b2b_blk3", 2 * N, VEC_CODED, 0, 1'b0);
      if (pq.size() >= 3 * N) begin
         check("b2b_gap12", W'(pq[N].t - pq[N-1].t), W'(20));
         check("b2b_gap23", W'(pq[2*N].t - pq[2*N-1].t), W'(20));
      end
      check("b2b_tail", W'(dut.sr_q), W'(tail_of(VEC)));

      // Reset while encoding bit 40 with the other bank partly written
      pq.delete();
      send_bits(VEC, N, 1'b0, st, tl);
      send_bits(~VEC, 40, 1'b0, st, tl);
      wait_pairs(40, 300);
      pre = out_valid;
      check("rst_precond", W'({pre, pq.size()[7:0]}), W'({1'b1, 8'd40}));
      reset = 1'b1;
      #1;
      check("rst_async", W'({out_valid, out_x, out_y, out_first, out_last, in_ready}),
            W'(6'b000001));
      @(negedge clk);
      reset = 1'b0;
      pq.delete();
      repeat (30) @(negedge clk);
      check("rst_no_output", W'(pq.size()), W'(0));
      send_bits(VEC, N, 1'b0, st, tl);
      wait_pairs(N, 600);
      repeat (10) @(negedge clk);
      #1;
      check("rst_count", W'(pq.size()), W'(N));
      check_block("rst_vec", 0, VEC_CODED, tl, 1'b1);
      check("rst_tail", W'(dut.sr_q), W'(tail_of(VEC)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
